seven_seg_scan: RTL and testbench

Parametrised, clocked, time-multiplexed driver for an N-digit common-anode seven-segment display. It replaces a purely combinational per-digit decoder. It adds:
- an internal refresh scan counter
- frame-synchronous input snapshot, so there is no tearing
- a per-digit anti-ghost blanking interval
- leading-zero suppression, a minus glyph, and decimal points

It sits between the multiplier result/BCD path and the board display pins.

---
 rtl/seven_seg_scan.sv | 150 +++++++++++++++
 tb/tb_seven_seg_scan.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: time-multiplexed driver for an N-digit common-anode
// seven-segment display. It takes a frame-synchronous snapshot of the inputs,
// blanks the anodes at the start of each digit slot to avoid ghosting, and
// handles leading-zero suppression, a minus glyph and decimal points.
module seven_seg_scan #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] digits,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
   input  logic                    lzs_en,
   input  logic                    en,
   output logic [6:0]              segments,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   anode_active,
   output logic                    frame_done
);

   localparam int CW = $clog2(REFRESH_DIV);
   localparam int IW = $clog2(NUM_DIGITS);
   localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

   logic [CW-1:0]              cnt;
   logic [IW-1:0]              idx;
   logic                       load_pending;
   logic                       slot_end;
   logic                       load;
   logic [NUM_DIGITS-1:0][3:0] snap_dig;
   logic [NUM_DIGITS-1:0]      snap_dp;
   logic [NUM_DIGITS-1:0]      snap_blank;
   logic                       snap_lzs;
   logic [NUM_DIGITS-1:0]      dark;
   logic                       lead;
   logic                       in_blank;
   logic [3:0]                 cur_code;
   logic                       cur_dark;
   logic                       cur_dp;
   logic [6:0]                 seg_nxt;
   logic                       dp_nxt;
   logic [NUM_DIGITS-1:0]      an_nxt;

   // Glyph codes to active-low {a,b,c,d,e,f,g}; 10 is minus, 11..15 blank.
   function automatic logic [6:0] decode(input logic [3:0] c);
      case (c)
         4'd0:    return 7'b0000001;
         4'd1:    return 7'b1001111;
         4'd2:    return 7'b0010010;
         4'd3:    return 7'b0000110;
         4'd4:    return 7'b1001100;
         4'd5:    return 7'b0100100;
         4'd6:    return 7'b0100000;
         4'd7:    return 7'b0001111;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0000100;
         4'd10:   return 7'b1111110;
         default: return 7'b1111111;
      endcase
   endfunction

   assign slot_end = (cnt == CNT_LAST);
   assign load     = load_pending | (slot_end & (idx == IDX_LAST));

   // Anti-ghost window at the start of each slot (absent when BLANK_CYCLES is 0).
   if (BLANK_CYCLES == 0) begin : g_noblank
      assign in_blank = 1'b0;
   end else begin : g_blank
      assign in_blank = (cnt < CW'(BLANK_CYCLES));
   end

   // Slot counter and digit index free-run regardless of en.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         idx <= '0;
      end else if (slot_end) begin
         cnt <= '0;
         idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Frame-boundary snapshot of all display inputs; frame_done marks each load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         snap_dig     <= '0;
         snap_dp      <= '0;
         snap_blank   <= '1;
         snap_lzs     <= 1'b0;
         load_pending <= 1'b1;
         frame_done   <= 1'b0;
      end else begin
         frame_done <= load;
         if (load) begin
            snap_dig     <= digits;
            snap_dp      <= dp_in;
            snap_blank   <= blank_in;
            snap_lzs     <= lzs_en;
            load_pending <= 1'b0;
         end
      end
   end

   // Per-digit dark flags: explicit blank, or a leading zero while suppression is on.
   always_comb begin
      lead = snap_lzs;
      dark = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (snap_dig[k] != 4'd0) lead = 1'b0;
         dark[k] = snap_blank[k] | (lead & (k != NUM_DIGITS - 1));
      end
   end

   // Select the current digit and form next segment/dp/anode values.
   always_comb begin
      cur_code = '0;
      cur_dark = 1'b1;
      cur_dp   = 1'b0;
      an_nxt   = '1;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx == IW'(k)) begin
            cur_code = snap_dig[k];
            cur_dark = dark[k];
            cur_dp   = snap_dp[k];
            an_nxt[NUM_DIGITS-1-k] = ~(en & ~in_blank);
         end
      end
      seg_nxt = cur_dark ? 7'b1111111 : decode(cur_code);
      dp_nxt  = cur_dark | ~cur_dp;
   end

   // Registered display pins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         segments     <= 7'b1111111;
         dp           <= 1'b1;
         anode_active <= '1;
      end else begin
         segments     <= seg_nxt;
         dp           <= dp_nxt;
         anode_active <= an_nxt;
      end
   end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan: directed scenarios plus random stimulus, all
// checked every cycle against a frame/slot-level reference model.
module tb_seven_seg_scan;
   localparam int ND = 4;
   localparam int RD = 4;
   localparam int BC = 1;
   localparam int FRAME = ND * RD;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [4*ND-1:0] digits;
   logic [ND-1:0] dp_in;
   logic [ND-1:0] blank_in;
   logic          lzs_en;
   logic          en;
   logic [6:0]    segments;
   logic          dp;
   logic [ND-1:0] anode_active;
   logic          frame_done;

   seven_seg_scan #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
      .clk(clk), .rst(rst), .digits(digits), .dp_in(dp_in), .blank_in(blank_in),
      .lzs_en(lzs_en), .en(en), .segments(segments), .dp(dp),
      .anode_active(anode_active), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // reference model state
   int            m_n;        // clock edges since reset release
   bit            m_pend;
   logic [3:0]    s_dig [ND];
   logic [ND-1:0] s_dp;
   logic [ND-1:0] s_blank;
   bit            s_lzs;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   function automatic logic [6:0] ref_seg(input logic [3:0] c);
      case (c)
         4'd0:    return 7'b0000001;
         4'd1:    return 7'b1001111;
         4'd2:    return 7'b0010010;
         4'd3:    return 7'b0000110;
         4'd4:    return 7'b1001100;
         4'd5:    return 7'b0100100;
         4'd6:    return 7'b0100000;
         4'd7:    return 7'b0001111;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0000100;
         4'd10:   return 7'b1111110;
         default: return 7'b1111111;
      endcase
   endfunction

   task automatic model_reset();
      m_n = 0;
      m_pend = 1'b1;
      for (int k = 0; k < ND; k++) s_dig[k] = 4'd0;
      s_dp = '0;
      s_blank = '1;
      s_lzs = 1'b0;
   endtask

   task automatic chk_reset();
      chk("rst_anode", anode_active, 4'hf);
      chk("rst_seg", segments, 7'h7f);
      chk("rst_dp", dp, 1'b1);
      chk("rst_frame_done", frame_done, 1'b0);
   endtask

   // One clock: predict, clock, compare, then advance the model.
   task automatic tick();
      int p, slot, ph, first;
      bit is_dark, e_fd, e_dp;
      logic [6:0] e_seg;
      logic [ND-1:0] e_an;
      p    = m_n % FRAME;
      slot = p / RD;
      ph   = p % RD;
      e_an = '1;
      if (en && ph >= BC) e_an[ND-1-slot] = 1'b0;
      first = ND - 1;
      for (int k = ND - 1; k >= 0; k--) if (s_dig[k] != 4'd0) first = k;
      is_dark = s_blank[slot] || (s_lzs && slot < first);
      e_seg = is_dark ? 7'h7f : ref_seg(s_dig[slot]);
      e_dp  = is_dark ? 1'b1 : ~s_dp[slot];
      e_fd  = m_pend || (p == FRAME - 1);
      @(posedge clk);
      #1;
      chk("anode", anode_active, e_an);
      chk("seg", segments, e_seg);
      chk("dp", dp, e_dp);
      chk("frame_done", frame_done, e_fd);
      if (e_fd) begin
         for (int k = 0; k < ND; k++) s_dig[k] = digits[4*k +: 4];
         s_dp = dp_in;
         s_blank = blank_in;
         s_lzs = lzs_en;
         m_pend = 1'b0;
      end
      m_n++;
   endtask

   // Asynchronous reset pulse placed mid-cycle, checked before any clock edge.
   task automatic mid_reset();
      #2 rst = 1'b1;
      #1 chk_reset();
      model_reset();
      #3 rst = 1'b0;
   endtask

   initial begin
      digits = '0; dp_in = '0; blank_in = '0; lzs_en = 1'b0; en = 1'b0;
      model_reset();
      #11 chk_reset();

      // basic scan of 3,2,1,0 -> digits 0..3 show 0,1,2,3
      digits = 16'h3210; en = 1'b1;
      #1 rst = 1'b0;
      repeat (20) tick();

      // snapshot isolation: change mid-frame
      while (m_n % FRAME != 6) tick();
      digits = 16'h9999;
      repeat (30) tick();

      // leading-zero suppression
      lzs_en = 1'b1; digits = 16'h0500;
      repeat (34) tick();
      digits = 16'h0000;
      repeat (34) tick();

      // minus, blank code, decimal point, forced blank
      lzs_en = 1'b0; digits = 16'h00ca; dp_in = 4'b0001; blank_in = 4'b1000;
      repeat (34) tick();

      // enable off for two frames, then back on
      en = 1'b0;
      repeat (32) tick();
      en = 1'b1;
      repeat (20) tick();

      // reset while counters sit at idx=2, cnt=2
      blank_in = '0; dp_in = 4'b1010; digits = 16'h4321;
      while (m_n % FRAME != 10) tick();
      mid_reset();
      repeat (24) tick();

      // random stimulus
      repeat (600) begin
         if ($urandom_range(0, 5) == 0) digits = 16'($urandom);
         if ($urandom_range(0, 9) == 0) digits = 16'($urandom) & 16'hff00;
         if ($urandom_range(0, 7) == 0) dp_in = 4'($urandom);
         if ($urandom_range(0, 9) == 0) blank_in = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
         if ($urandom_range(0, 9) == 0) lzs_en = 1'($urandom);
         if ($urandom_range(0, 11) == 0) en = 1'($urandom);
         if ($urandom_range(0, 199) == 0) mid_reset();
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
